// File: rtl/mult_stim_gen_pkg.sv
// Shared types and default widths for the mult_stim_gen operand-stream generator.
package mult_pkg;

    localparam int unsigned A_W   = 11;
    localparam int unsigned B_W   = 11;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    function automatic int unsigned prod_w(input int unsigned aw, input int unsigned bw);
        return aw + bw - 1;
    endfunction

endpackage

// File: rtl/mult_stim_gen_if.sv
// Operand-stream bus between mult_stim_gen and its consumer.
// Optional expected-product signals appear when MULT_STIM_EXPECT_EN is defined.
interface mult_stim_gen_if #(
    parameter int unsigned A_W   = 11,
    parameter int unsigned B_W   = 11,
    parameter int unsigned CNT_W = 8
) ();
    localparam int unsigned PW = mult_pkg::prod_w(A_W, B_W);

    logic             start;
    logic [A_W-1:0]   a_base;
    logic [B_W-1:0]   b_base;
    logic [A_W-1:0]   a_step;
    logic [B_W-1:0]   b_step;
    logic [CNT_W-1:0] num_pairs;
    logic [CNT_W-1:0] hold;

    logic [A_W-1:0]   A;
    logic [B_W-1:0]   B;
    logic             valid;
    logic             busy;
    logic             done;
`ifdef MULT_STIM_EXPECT_EN
    logic [PW-1:0]    exp_p;
    logic             exp_match;
`endif

    modport master (
        input  start, a_base, b_base, a_step, b_step, num_pairs, hold,
        output A, B, valid, busy, done
`ifdef MULT_STIM_EXPECT_EN
        , output exp_p, exp_match
`endif
    );

    modport slave (
        output start, a_base, b_base, a_step, b_step, num_pairs, hold,
        input  A, B, valid, busy, done
`ifdef MULT_STIM_EXPECT_EN
        , input exp_p, exp_match
`endif
    );

endinterface

// File: rtl/mult_stim_gen_hold_ctr.sv
// Hold/pair counter pair for mult_stim_gen: strobes step (advance operands) and
// last (final cycle of the final pair).
module stim_hold_ctr #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] hold_i,
    input  logic [CNT_W-1:0] num_pairs_i,
    output logic             step_o,
    output logic             last_o
);
    localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic             hold_hit;
    logic             last_pair;

    always_comb begin
        hold_hit  = (hold_cnt_q == hold_i);
        // Only meaningful while en_i, where num_pairs_i is known to be non-zero.
        last_pair = (pair_cnt_q == num_pairs_i - One);
        step_o    = en_i && hold_hit && !last_pair;
        last_o    = en_i && hold_hit && last_pair;
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        pair_cnt_d = pair_cnt_q;
        if (clear_i) begin
            hold_cnt_d = '0;
            pair_cnt_d = '0;
        end else if (en_i) begin
            if (hold_hit) begin
                hold_cnt_d = '0;
                if (!last_pair) begin
                    pair_cnt_d = pair_cnt_q + One;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + One;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            pair_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

endmodule

// File: rtl/mult_stim_gen.sv
// Operand-stream generator: emits stepped (A, B) pairs, each held hold+1 cycles.
// Define MULT_STIM_EXPECT_EN to add the registered expected-product outputs.
module mult_stim_gen #(
    parameter int unsigned A_W   = mult_pkg::A_W,
    parameter int unsigned B_W   = mult_pkg::B_W,
    parameter int unsigned CNT_W = mult_pkg::CNT_W,
    parameter logic [A_W+B_W-2:0] PATTERN = 21'd24
) (
    input  logic            clk,
    input  logic            rst,
    mult_stim_gen_if.master bus
);
    import mult_pkg::*;

    state_e           state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [A_W-1:0]   a_step_q, a_step_d;
    logic [B_W-1:0]   b_step_q, b_step_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ctr_clear;
    logic ctr_en;
    logic ctr_step;
    logic ctr_last;

    stim_hold_ctr #(
        .CNT_W (CNT_W)
    ) u_hold_ctr (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (ctr_clear),
        .en_i        (ctr_en),
        .hold_i      (hold_q),
        .num_pairs_i (num_q),
        .step_o      (ctr_step),
        .last_o      (ctr_last)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_step_d  = a_step_q;
        b_step_d  = b_step_q;
        num_d     = num_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // done_q high means this is the done-pulse cycle; start is ignored there.
                if (bus.start && !done_q) begin
                    a_step_d  = bus.a_step;
                    b_step_d  = bus.b_step;
                    num_d     = bus.num_pairs;
                    hold_d    = bus.hold;
                    busy_d    = 1'b1;
                    ctr_clear = 1'b1;
                    if (bus.num_pairs != '0) begin
                        a_d     = bus.a_base;
                        b_d     = bus.b_base;
                        valid_d = 1'b1;
                        state_d = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRun: begin
                ctr_en = 1'b1;
                if (ctr_last) begin
                    valid_d = 1'b0;
                    state_d = StFin;
                end else if (ctr_step) begin
                    a_d = a_q + a_step_q;
                    b_d = b_q + b_step_q;
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            a_step_q <= '0;
            b_step_q <= '0;
            num_q    <= '0;
            hold_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_step_q <= a_step_d;
            b_step_q <= b_step_d;
            num_q    <= num_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

`ifdef MULT_STIM_EXPECT_EN
    localparam int unsigned PW = prod_w(A_W, B_W);

    logic [A_W+B_W-1:0] prod_full;
    logic [PW-1:0]      exp_p_q, exp_p_d;
    logic               exp_match_q, exp_match_d;

    // Registered to line up with the detector's one-cycle registered output.
    always_comb begin
        prod_full   = {{B_W{1'b0}}, a_q} * {{A_W{1'b0}}, b_q};
        exp_p_d     = prod_full[PW-1:0];
        exp_match_d = (prod_full == {1'b0, PATTERN}) && valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_p_q     <= '0;
            exp_match_q <= 1'b0;
        end else begin
            exp_p_q     <= exp_p_d;
            exp_match_q <= exp_match_d;
        end
    end

    assign bus.exp_p     = exp_p_q;
    assign bus.exp_match = exp_match_q;
`endif

endmodule

// File: tb/tb_mult_stim_gen.sv
// Self-checking bench for mult_stim_gen against a queue-based sequence model.
module tb_mult_stim_gen;
    localparam int unsigned AW = 11;
    localparam int unsigned BW = 11;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_stim_gen_if #(.A_W(AW), .B_W(BW), .CNT_W(CW)) bus ();

    mult_stim_gen #(
        .A_W     (AW),
        .B_W     (BW),
        .CNT_W   (CW),
        .PATTERN (21'd24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model's knowledge of the operands the DUT currently presents.
    logic [AW-1:0] m_a;
    logic [BW-1:0] m_b;

    task automatic scramble_cfg();
        bus.a_base    = AW'($urandom);
        bus.b_base    = BW'($urandom);
        bus.a_step    = AW'($urandom);
        bus.b_step    = BW'($urandom);
        bus.num_pairs = CW'($urandom);
        bus.hold      = CW'($urandom);
    endtask

    // Called at a negedge. Starts a sequence and checks every cycle until idle again.
    task automatic run_seq(input string name, input logic [AW-1:0] ab, input logic [BW-1:0] bb,
                           input logic [AW-1:0] as, input logic [BW-1:0] bs,
                           input int np, input int hd, input bit noise);
        logic [AW-1:0] qa[$];
        logic [BW-1:0] qb[$];
        logic [AW-1:0] prev_a;
        logic [BW-1:0] prev_b;
        bit            prev_v;
        int            pr;
        for (int p = 0; p < np; p++) begin
            for (int h = 0; h <= hd; h++) begin
                qa.push_back(AW'((int'(ab) + p * int'(as)) % (1 << AW)));
                qb.push_back(BW'((int'(bb) + p * int'(bs)) % (1 << BW)));
            end
        end
        bus.a_base = ab; bus.b_base = bb; bus.a_step = as; bus.b_step = bs;
        bus.num_pairs = CW'(np); bus.hold = CW'(hd);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev_a = m_a; prev_b = m_b; prev_v = 1'b0;
        for (int i = 0; i < qa.size(); i++) begin
            checks++;
            if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.A !== qa[i] || bus.B !== qb[i]) begin
                errors++;
                $display("FAIL %s pair cyc%0d: got v=%b busy=%b done=%b A=%h B=%h want v=1 busy=1 done=0 A=%h B=%h",
                         name, i, bus.valid, bus.busy, bus.done, bus.A, bus.B, qa[i], qb[i]);
            end
`ifdef MULT_STIM_EXPECT_EN
            pr = int'(prev_a) * int'(prev_b);
            checks++;
            if (bus.exp_p !== 21'(pr) || bus.exp_match !== (prev_v && pr == 24)) begin
                errors++;
                $display("FAIL %s exp cyc%0d: got p=%0d m=%b want p=%0d m=%b", name, i,
                         bus.exp_p, bus.exp_match, 21'(pr), prev_v && pr == 24);
            end
`endif
            prev_a = qa[i]; prev_b = qb[i]; prev_v = 1'b1;
            if (noise) begin
                scramble_cfg();
                bus.start = 1'($urandom);
            end
            @(negedge clk);
        end
        if (qa.size() > 0) begin
            m_a = qa[qa.size()-1];
            m_b = qb[qb.size()-1];
        end
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
            bus.A !== m_a || bus.B !== m_b) begin
            errors++;
            $display("FAIL %s tail: got v=%b busy=%b done=%b A=%h B=%h want v=0 busy=1 done=0 A=%h B=%h",
                     name, bus.valid, bus.busy, bus.done, bus.A, bus.B, m_a, m_b);
        end
`ifdef MULT_STIM_EXPECT_EN
        pr = int'(prev_a) * int'(prev_b);
        checks++;
        if (bus.exp_p !== 21'(pr) || bus.exp_match !== (prev_v && pr == 24)) begin
            errors++;
            $display("FAIL %s exp tail: got p=%0d m=%b want p=%0d m=%b", name,
                     bus.exp_p, bus.exp_match, 21'(pr), prev_v && pr == 24);
        end
`endif
        if (noise) bus.start = 1'($urandom);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 ||
            bus.A !== m_a || bus.B !== m_b) begin
            errors++;
            $display("FAIL %s done: got done=%b busy=%b v=%b A=%h B=%h want done=1 busy=0 v=0 A=%h B=%h",
                     name, bus.done, bus.busy, bus.valid, bus.A, bus.B, m_a, m_b);
        end
        // A start during the done pulse must be ignored.
        bus.start = noise;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got done=%b busy=%b v=%b want 0 0 0",
                     name, bus.done, bus.busy, bus.valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        scramble_cfg();
        #3;
        checks++;
        if (bus.A !== '0 || bus.B !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got A=%h B=%h v=%b busy=%b done=%b want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done);
        end
`ifdef MULT_STIM_EXPECT_EN
        checks++;
        if (bus.exp_p !== '0 || bus.exp_match !== 1'b0) begin
            errors++;
            $display("FAIL reset exp: got p=%0d m=%b want 0 0", bus.exp_p, bus.exp_match);
        end
`endif
        m_a = '0;
        m_b = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_baseline();
        run_seq("baseline", 11'd12, 11'd2, 11'd0, 11'd1, 2, 14, 1'b0);
    endtask

    task automatic test_hold_zero();
        run_seq("hold0", 11'd1, 11'd1, 11'd1, 11'd0, 4, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_seq("wrap", 11'h7FE, 11'h7FF, 11'd1, 11'd3, 3, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_seq("empty", 11'd5, 11'd6, 11'd1, 11'd1, 0, 3, 1'b0);
    endtask

    task automatic test_start_busy();
        // Scrambled config and random start pulses while busy must not disturb the run.
        run_seq("busy_start", 11'd100, 11'd7, 11'd3, 11'h7FF, 3, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_seq("b2b_0", 11'd9, 11'd4, 11'd2, 11'd5, 2, 1, 1'b1);
        run_seq("b2b_1", 11'd3, 11'd8, 11'd1, 11'd1, 3, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            run_seq("random", AW'($urandom), BW'($urandom), AW'($urandom), BW'($urandom),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bus.a_base = 11'd12; bus.b_base = 11'd2; bus.a_step = 11'd0; bus.b_step = 11'd1;
        bus.num_pairs = 8'd2; bus.hold = 8'd14;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.A !== '0 || bus.B !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: got A=%h B=%h v=%b busy=%b done=%b want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done);
        end
        m_a = '0;
        m_b = '0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid after: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_hold_zero();
        test_wrap();
        test_empty();
        test_start_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_baseline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_stim_gen.md
Name: mult_stim_gen

Overview:
- Operand-stream generator: the driving end of the multiply/pattern-detect path.
- Emits a programmed sequence of (A, B) operand pairs into the multiplier whose product the pattern detector checks.
- Each pair is held for a programmable number of cycles, then both operands step by programmed increments.
- Replaces hand-written operand sequencing in benches and serves as the on-chip stimulus source for the detector.

Parameters:
- A_W, 11, operand A width in bits.
- B_W, 11, operand B width in bits.
- CNT_W, 8, width of the pair-count and hold-count fields.
- PATTERN, 21'd24, product value compared by the optional expected-product logic. Width is A_W+B_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sequence; ignored while busy.
- a_base  input  A_W  first A operand.
- b_base  input  B_W  first B operand.
- a_step  input  A_W  A increment per step.
- b_step  input  B_W  B increment per step.
- num_pairs  input  CNT_W  number of operand pairs to emit.
- hold  input  CNT_W  extra cycles each pair is held; each pair is presented for hold+1 cycles.
- A  output  A_W  operand A to the multiplier.
- B  output  B_W  operand B to the multiplier.
- valid  output  1  A/B carry a live operand pair.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset: A=0, B=0, valid=0, busy=0, done=0, FSM in IDLE, all internal counters 0.
- Reset asserted mid-sequence aborts it immediately. No done pulse is generated.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start=1, latch a_base, b_base, a_step, b_step, num_pairs and hold.
  - If num_pairs≠0: the next edge gives A=a_base, B=b_base, valid=1, busy=1, and the FSM enters RUN.
  - If num_pairs=0: go to FIN with valid=0 (busy=1 for that one cycle).
- RUN:
  - hold_cnt counts 0..hold.
  - Every edge where hold_cnt==hold and pair_cnt<num_pairs-1: A<=A+a_step, B<=B+b_step, pair_cnt++, hold_cnt<=0.
  - When hold_cnt==hold and pair_cnt==num_pairs-1: valid<=0, go to FIN.
  - First pair valid starts the cycle after start. Total valid cycles = num_pairs*(hold+1), contiguous, with no gaps.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. A/B keep their last values.
- Arithmetic: operand steps wrap modulo 2^A_W and 2^B_W. No saturation and no overflow flag.
- start while busy or in FIN is ignored. Latched config is unaffected by input changes during a sequence.
- start asserted in the same cycle done pulses is ignored. start in the following IDLE cycle is accepted.
- hold=0 means a new pair every cycle.
- Maximum sequence length is num_pairs=2^CNT_W-1.

Optional Feature:
- Macro: MULT_STIM_EXPECT_EN.
- When defined, adds outputs exp_p (A_W+B_W-1 bits) and exp_match (1 bit).
  - exp_p is the registered product A*B; exp_match=(A*B==PATTERN)&valid.
  - Both are registered one cycle after A/B, matching the detector's one-cycle registered output.
  - Both reset to 0.
- When undefined, neither port nor the multiplier is present. The remaining behaviour is identical.

Decomposition:
- Shared package mult_pkg:
  - Default widths A_W, B_W, CNT_W.
  - Typedef of the FSM state enum (IDLE/RUN/FIN).
  - Product width function A_W+B_W-1.
- One natural sub-module, stim_hold_ctr: hold/pair counter pair producing step and last strobes.
- The FSM and the operand registers stay in the top level.

Test Plan:
- Baseline: a_base=12, b_base=2, a_step=0, b_step=1, num_pairs=2, hold=14, start pulse.
  - Required: A=12, B=2 for 15 cycles, then A=12, B=3 for 15 cycles.
  - valid high for 30 cycles; done pulses one cycle after valid falls.
- Hold zero: a_base=1, a_step=1, b_base=1, b_step=0, num_pairs=4, hold=0.
  - Required: A=1,2,3,4 on consecutive cycles, B=1 throughout, valid for 4 cycles.
- Wrap: a_base=11'h7FE, a_step=1, num_pairs=3, hold=0.
  - Required: A=7FE,7FF,000.
- Empty sequence: num_pairs=0.
  - Required: valid never rises; done pulses 2 cycles after start.
- Reset and start handling:
  - Assert rst mid-RUN. Required: A=B=0, valid=busy=done=0 asynchronously; no done afterwards.
  - A start during busy is ignored.
- With MULT_STIM_EXPECT_EN: baseline stimulus, PATTERN=24.
  - Required: exp_match=1 for 15 cycles starting one cycle after valid rises.
  - exp_p=36 during the second pair with exp_match=0.
